// File: rtl/uart_aes_pkg.sv
// Shared definitions for the AES-over-UART receive path.
// Holds the state encoding, the error codes and the output decode.
package uart_aes_pkg;

  localparam int FRAME_BYTES_DEFAULT = 18;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_CRC_WAIT  = 3'd3,
    ST_AES_WAIT  = 3'd4,
    ST_AES_GO    = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  localparam logic [1:0] ERR_CRC     = 2'b00;
  localparam logic [1:0] ERR_FRAME   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef struct packed {
    logic busy;
    logic sipo_reset;
    logic sipo_load;
    logic crc_clear;
    logic en_crc;
    logic aes_start;
    logic frame_ok;
    logic frame_err;
  } ctrl_t;

  // Moore decode: each state owns a fixed set of strobes.
  function automatic ctrl_t decode_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    c.busy = (s != ST_IDLE);
    case (s)
      ST_IDLE: begin
        c.sipo_reset = 1'b1;
        c.crc_clear  = 1'b1;
      end
      ST_SHIFT: begin
        c.sipo_load = 1'b1;
        c.en_crc    = 1'b1;
      end
      ST_AES_GO: c.aes_start = 1'b1;
      ST_DONE:   c.frame_ok  = 1'b1;
      ST_ERROR:  c.frame_err = 1'b1;
      default:   c = c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_frame_controller_timeout.sv
// Idle-cycle counter for the receive controller.
// Flags expiry once TIMEOUT_CYCLES-1 enabled cycles have been counted since the last clear.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT_CYCLES - 1));

  // Holds at the expiry value so a stalled caller never sees a wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_controller.sv
// Receive-side frame sequencer: UART Rx bytes -> SIPO + CRC16 -> AES core.
// Moore FSM with registered strobes; errors reported through a held err_code.
module uart_rx_frame_controller
  import uart_aes_pkg::*;
#(
  parameter int FRAME_BYTES    = FRAME_BYTES_DEFAULT,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  input  logic       crc_valid,
  input  logic       crc_ok,
  input  logic       aes_ready,
  output logic       busy,
  output logic       sipo_reset,
  output logic       sipo_load,
  output logic       crc_clear,
  output logic       en_crc,
  output logic [4:0] byte_idx,
  output logic       aes_start,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES - 1);
  localparam logic [4:0] FULL_CNT = 5'(FRAME_BYTES);

  state_t     state, nxt_state;
  logic [4:0] byte_cnt, nxt_cnt;
  logic [1:0] err_reg, nxt_err;
  ctrl_t      ctrl;
  logic       timer_clear, timer_en, timer_expired;

  // The data byte goes straight to the SIPO outside this block.
  logic unused_rx_data;
  assign unused_rx_data = ^rx_data;

  assign timer_clear = ((state == ST_IDLE) && start) || (state == ST_SHIFT);
  assign timer_en    = ((state == ST_WAIT_BYTE) && (byte_cnt != 5'd0)) ||
                       (state == ST_CRC_WAIT);

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    nxt_state = state;
    nxt_cnt   = byte_cnt;
    nxt_err   = err_reg;
    case (state)
      ST_IDLE: begin
        if (start) begin
          nxt_state = ST_WAIT_BYTE;
          nxt_cnt   = 5'd0;
          nxt_err   = ERR_CRC;
        end
      end
      ST_WAIT_BYTE: begin
        if (rx_valid && rx_err) begin
          nxt_state = ST_ERROR;
          nxt_err   = ERR_FRAME;
        end else if (rx_valid) begin
          nxt_state = ST_SHIFT;
        end else if (timer_expired && (byte_cnt != 5'd0)) begin
          nxt_state = ST_ERROR;
          nxt_err   = ERR_TIMEOUT;
        end
      end
      ST_SHIFT: begin
        if (byte_cnt != FULL_CNT) nxt_cnt = byte_cnt + 5'd1;
        // A second byte arriving while the first is still shifting is lost data.
        if (rx_valid) begin
          nxt_state = ST_ERROR;
          nxt_err   = ERR_OVERRUN;
        end else if (byte_cnt == LAST_IDX) begin
          nxt_state = ST_CRC_WAIT;
        end else begin
          nxt_state = ST_WAIT_BYTE;
        end
      end
      ST_CRC_WAIT: begin
        if (crc_valid && crc_ok) begin
          nxt_state = ST_AES_WAIT;
        end else if (crc_valid) begin
          nxt_state = ST_ERROR;
          nxt_err   = ERR_CRC;
        end else if (timer_expired) begin
          nxt_state = ST_ERROR;
          nxt_err   = ERR_TIMEOUT;
        end else if (rx_valid) begin
          nxt_state = ST_ERROR;
          nxt_err   = ERR_OVERRUN;
        end
      end
      ST_AES_WAIT: if (aes_ready) nxt_state = ST_AES_GO;
      ST_AES_GO:   nxt_state = ST_DONE;
      ST_DONE:     nxt_state = ST_IDLE;
      ST_ERROR:    nxt_state = ST_IDLE;
      default:     nxt_state = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      byte_cnt <= 5'd0;
      err_reg  <= ERR_CRC;
      ctrl     <= decode_ctrl(ST_IDLE);
    end else begin
      state    <= nxt_state;
      byte_cnt <= nxt_cnt;
      err_reg  <= nxt_err;
      ctrl     <= decode_ctrl(nxt_state);
    end
  end

  assign busy       = ctrl.busy;
  assign sipo_reset = ctrl.sipo_reset;
  assign sipo_load  = ctrl.sipo_load;
  assign crc_clear  = ctrl.crc_clear;
  assign en_crc     = ctrl.en_crc;
  assign aes_start  = ctrl.aes_start;
  assign frame_ok   = ctrl.frame_ok;
  assign frame_err  = ctrl.frame_err;
  assign byte_idx   = byte_cnt;
  assign err_code   = err_reg;

endmodule

// File: tb/tb_uart_rx_frame_controller.sv
// Scoreboard bench for uart_rx_frame_controller: random frame scenarios,
// expected strobe events queued by the stimulus and matched by a monitor.
module tb_uart_rx_frame_controller;

  localparam int FB = 18;
  localparam int TO = 64;

  localparam int SC_GOOD        = 0;
  localparam int SC_CRC_BAD     = 1;
  localparam int SC_FRAMING     = 2;
  localparam int SC_TIMEOUT     = 3;
  localparam int SC_OVERRUN     = 4;
  localparam int SC_AES_WAIT    = 5;
  localparam int SC_CRC_TIMEOUT = 6;
  localparam int SC_CRC_OVERRUN = 7;
  localparam int SC_RESET       = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_err = 1'b0;
  logic       crc_valid = 1'b0;
  logic       crc_ok = 1'b0;
  logic       aes_ready = 1'b0;
  logic       busy, sipo_reset, sipo_load, crc_clear, en_crc;
  logic [4:0] byte_idx;
  logic       aes_start, frame_ok, frame_err;
  logic [1:0] err_code;

  uart_rx_frame_controller #(
    .FRAME_BYTES   (FB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_err    (rx_err),
    .crc_valid (crc_valid),
    .crc_ok    (crc_ok),
    .aes_ready (aes_ready),
    .busy      (busy),
    .sipo_reset(sipo_reset),
    .sipo_load (sipo_load),
    .crc_clear (crc_clear),
    .en_crc    (en_crc),
    .byte_idx  (byte_idx),
    .aes_start (aes_start),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef enum int {EV_LOAD, EV_AES, EV_OK, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       idx;
    int       err;
  } ev_t;

  ev_t exp_q[$];

  task automatic expect_ev(input ev_kind_t k, input int c, input int idx, input int err);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.idx  = idx;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pop_check(input ev_kind_t k);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_%s: cycle %0d byte_idx=%0d err_code=%0d, wanted no event",
               k.name(), cyc, byte_idx, err_code);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.idx != int'(byte_idx) ||
          (e.err >= 0 && e.err != int'(err_code)) || (k == EV_LOAD && en_crc !== 1'b1)) begin
        bad++;
        $display("[TB] FAIL event: got %s cyc=%0d idx=%0d err=%0d en_crc=%0b, wanted %s cyc=%0d idx=%0d err=%0d",
                 k.name(), cyc, byte_idx, err_code, en_crc, e.kind.name(), e.cyc, e.idx, e.err);
      end
    end
  endtask

  // Monitor: every strobe the DUT raises must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sipo_load) pop_check(EV_LOAD);
      if (aes_start) pop_check(EV_AES);
      if (frame_ok)  pop_check(EV_OK);
      if (frame_err) pop_check(EV_ERR);
    end
  end

  task automatic finish_frame(input int exp_idx, input int exp_err);
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    checkOutput("idle_reached", int'(busy), 0);
    if (busy) begin
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      exp_q.delete();
    end
    checkOutput("byte_idx_after", int'(byte_idx), exp_idx);
    checkOutput("err_code_after", int'(err_code), exp_err);
    checkOutput("sipo_reset_idle", int'(sipo_reset), 1);
    tick(2);
  endtask

  task automatic applyStimulus(input int sc, input int param);
    int nbytes, err_at, ovr_at, last_load, d;
    nbytes    = FB;
    err_at    = -1;
    ovr_at    = -1;
    last_load = 0;
    if (sc == SC_FRAMING) err_at = param;
    if (sc == SC_OVERRUN) ovr_at = param;
    if (sc == SC_TIMEOUT || sc == SC_RESET) nbytes = param;
    aes_ready = (sc != SC_AES_WAIT);

    start = 1'b1;
    tick();
    start = 1'b0;
    tick((sc == SC_GOOD) ? param : $urandom_range(0, 10));

    for (int k = 0; k < nbytes; k++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      rx_err   = (k == err_at);
      if (k == err_at) begin
        expect_ev(EV_ERR, cyc + 1, k, 1);
        tick();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        finish_frame(k, 1);
        return;
      end
      expect_ev(EV_LOAD, cyc + 1, k, -1);
      last_load = cyc + 1;
      if (k == ovr_at) begin
        expect_ev(EV_ERR, cyc + 2, k + 1, 3);
        tick(2);
        rx_valid = 1'b0;
        finish_frame(k + 1, 3);
        return;
      end
      tick();
      rx_valid = 1'b0;
      if (sc == SC_GOOD && k == 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (k < nbytes - 1) tick($urandom_range(1, 49));
    end

    if (sc == SC_TIMEOUT) begin
      expect_ev(EV_ERR, last_load + TO + 1, nbytes, 2);
      finish_frame(nbytes, 2);
      return;
    end
    if (sc == SC_RESET) begin
      tick($urandom_range(2, 20));
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_byte_idx", int'(byte_idx), 0);
      checkOutput("reset_sipo_reset", int'(sipo_reset), 1);
      tick(2);
      return;
    end
    if (sc == SC_CRC_TIMEOUT) begin
      expect_ev(EV_ERR, last_load + TO + 1, FB, 2);
      finish_frame(FB, 2);
      return;
    end

    tick($urandom_range(1, 8));
    if (sc == SC_CRC_OVERRUN) begin
      rx_valid = 1'b1;
      expect_ev(EV_ERR, cyc + 1, FB, 3);
      tick();
      rx_valid = 1'b0;
      finish_frame(FB, 3);
      return;
    end

    crc_valid = 1'b1;
    crc_ok    = (sc != SC_CRC_BAD);
    d = cyc;
    if (sc == SC_CRC_BAD) begin
      expect_ev(EV_ERR, d + 1, FB, 0);
    end else if (sc == SC_GOOD) begin
      expect_ev(EV_AES, d + 2, FB, 0);
      expect_ev(EV_OK, d + 3, FB, 0);
    end
    tick();
    crc_valid = 1'b0;
    crc_ok    = 1'b0;
    if (sc == SC_AES_WAIT) begin
      tick(19);
      checkOutput("aes_wait_busy", int'(busy), 1);
      aes_ready = 1'b1;
      expect_ev(EV_AES, cyc + 1, FB, 0);
      expect_ev(EV_OK, cyc + 2, FB, 0);
    end
    finish_frame(FB, 0);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc, param;
    reset_n = 1'b0;
    tick(3);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_sipo_reset", int'(sipo_reset), 1);
    checkOutput("rst_crc_clear", int'(crc_clear), 1);
    checkOutput("rst_sipo_load", int'(sipo_load), 0);
    checkOutput("rst_byte_idx", int'(byte_idx), 0);
    checkOutput("rst_err_code", int'(err_code), 0);
    reset_n = 1'b1;
    tick(2);

    applyStimulus(SC_GOOD, 1000);
    applyStimulus(SC_CRC_BAD, 0);
    applyStimulus(SC_FRAMING, 4);
    applyStimulus(SC_TIMEOUT, 3);
    applyStimulus(SC_OVERRUN, 7);
    applyStimulus(SC_OVERRUN, FB - 1);
    applyStimulus(SC_AES_WAIT, 0);
    applyStimulus(SC_CRC_TIMEOUT, 0);
    applyStimulus(SC_CRC_OVERRUN, 0);
    applyStimulus(SC_RESET, 9);
    applyStimulus(SC_GOOD, 0);

    repeat (12) begin
      sc = $urandom_range(0, 8);
      case (sc)
        SC_GOOD:    param = $urandom_range(0, 30);
        SC_FRAMING: param = $urandom_range(0, FB - 1);
        SC_TIMEOUT: param = $urandom_range(1, FB - 1);
        SC_OVERRUN: param = $urandom_range(0, FB - 1);
        SC_RESET:   param = $urandom_range(1, FB - 1);
        default:    param = 0;
      endcase
      applyStimulus(sc, param);
    end

    tick(3);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
